output_writeback_ctrl: RTL and testbench

//  Write-side counterpart of the conv controller: the controller reads act/kernel SRAM into the PE array; this block writes results back.

---
 rtl/conv_pkg.sv | 15 +
 rtl/fmap_pixel_counter.sv | 55 +++++
 rtl/output_writeback_ctrl.sv | 162 ++++++++++++++++
 tb/tb_output_writeback_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Constants and FSM encodings shared by the conv read-side controller and the output write-back path.
package conv_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned NUM_CH_DEF = 6;
  localparam int unsigned ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } conv_state_e;

endpackage

// File: rtl/fmap_pixel_counter.sv
// Row/column walker over a square feature map; pix_addr is the raster index row*size+col.
module fmap_pixel_counter #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [7:0]        size_i,
  output logic [ADDR_W-1:0] pix_addr_o,
  output logic              last_pixel_o
);

  logic [7:0]        row_q, row_d;
  logic [7:0]        col_q, col_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [7:0]        size_m1;

  assign size_m1      = size_i - 8'd1;
  assign last_pixel_o = (row_q == size_m1) && (col_q == size_m1);
  assign pix_addr_o   = pix_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    pix_d = pix_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
      pix_d = '0;
    end else if (advance_i) begin
      pix_d = pix_q + ADDR_W'(1);
      if (col_q == size_m1) begin
        col_d = '0;
        // Wrap the row too on the final pixel so neither counter passes its limit.
        row_d = (row_q == size_m1) ? '0 : row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
      pix_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      pix_q <= pix_d;
    end
  end

endmodule

// File: rtl/output_writeback_ctrl.sv
// Captures one NUM_CH-wide pixel from the PE array and serializes it into channel-planar
// output SRAM writes (addr = ch*ch_stride + pixel index), with optional ReLU clamping.
module output_writeback_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter bit          RELU   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               size_out,
  input  logic [ADDR_W-1:0]        ch_stride,
  input  logic                     pe_valid,
  input  logic [NUM_CH*DATA_W-1:0] pe_data,
  output logic                     pe_ready,
  output logic [ADDR_W-1:0]        address_out,
  output logic [DATA_W-1:0]        wdata_out,
  output logic                     enable_out_sram,
  output logic                     write_en_out_sram,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned      CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);

  conv_state_e               state_q, state_d;
  logic [7:0]                size_q, size_d;
  logic [ADDR_W-1:0]         stride_q, stride_d;
  logic [NUM_CH*DATA_W-1:0]  hold_q, hold_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [ADDR_W-1:0]         ch_off_q, ch_off_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic                      wen_q, wen_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      cnt_clear, cnt_advance, last_pixel;
  logic [ADDR_W-1:0]         pix_addr;

  function automatic logic [DATA_W-1:0] wb_word(input logic [DATA_W-1:0] w);
    return (RELU && w[DATA_W-1]) ? '0 : w;
  endfunction

  fmap_pixel_counter #(.ADDR_W(ADDR_W)) u_pix_cnt (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (cnt_clear),
    .advance_i    (cnt_advance),
    .size_i       (size_q),
    .pix_addr_o   (pix_addr),
    .last_pixel_o (last_pixel)
  );

  // Outputs are registered, so each transition computes the SRAM word for the cycle it enters:
  // the capture edge already presents channel 0, giving NUM_CH+1 cycles per pixel.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    stride_d    = stride_q;
    hold_d      = hold_q;
    ch_d        = ch_q;
    ch_off_d    = ch_off_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (size_out != '0)) begin
          size_d    = size_out;
          stride_d  = ch_stride;
          cnt_clear = 1'b1;
          busy_d    = 1'b1;
          ready_d   = 1'b1;
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (pe_valid && ready_q) begin
          hold_d   = pe_data;
          ch_d     = '0;
          ch_off_d = '0;
          addr_d   = pix_addr;
          wdata_d  = wb_word(pe_data[DATA_W-1:0]);
          wen_d    = 1'b1;
          ready_d  = 1'b0;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (ch_q != CH_LAST) begin
          ch_d     = ch_q + 1'b1;
          ch_off_d = ch_off_q + stride_q;
          addr_d   = pix_addr + ch_off_d;
          wdata_d  = wb_word(hold_q[ch_d*DATA_W +: DATA_W]);
          wen_d    = 1'b1;
        end else begin
          cnt_advance = 1'b1;
          if (last_pixel) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            ready_d = 1'b1;
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      size_q   <= '0;
      stride_q <= '0;
      hold_q   <= '0;
      ch_q     <= '0;
      ch_off_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      stride_q <= stride_d;
      hold_q   <= hold_d;
      ch_q     <= ch_d;
      ch_off_q <= ch_off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pe_ready          = ready_q;
  assign address_out       = addr_q;
  assign wdata_out         = wdata_q;
  assign enable_out_sram   = wen_q;
  assign write_en_out_sram = wen_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_output_writeback_ctrl.sv
// Bench for output_writeback_ctrl: a cycle model built from pixel/write queues checks both a
// ReLU and a pass-through instance every cycle; directed scenarios pin the model with literals.
module tb_output_writeback_ctrl;
  localparam int DW = 16;
  localparam int NC = 6;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset, start, pe_valid;
  logic [7:0]    size_out;
  logic [AW-1:0] ch_stride;
  logic [NC*DW-1:0] pe_data;

  logic          pe_ready, en, we, busy, done;
  logic [AW-1:0] address_out;
  logic [DW-1:0] wdata_out;
  logic          pe_ready0, en0, we0, busy0, done0;
  logic [AW-1:0] address_out0;
  logic [DW-1:0] wdata_out0;

  output_writeback_ctrl #(.DATA_W(DW), .NUM_CH(NC), .ADDR_W(AW), .RELU(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .size_out(size_out), .ch_stride(ch_stride),
    .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_ready), .address_out(address_out),
    .wdata_out(wdata_out), .enable_out_sram(en), .write_en_out_sram(we), .busy(busy), .done(done)
  );

  output_writeback_ctrl #(.DATA_W(DW), .NUM_CH(NC), .ADDR_W(AW), .RELU(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .size_out(size_out), .ch_stride(ch_stride),
    .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_ready0), .address_out(address_out0),
    .wdata_out(wdata_out0), .enable_out_sram(en0), .write_en_out_sram(we0), .busy(busy0),
    .done(done0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
    return d[DW-1] ? '0 : d;
  endfunction

  // Model: expected state of the current cycle; writes of a captured pixel queue up in order.
  logic          m_busy = 0, m_ready = 0, m_done = 0, m_en = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_pix = 0, m_npix = 0;
  logic [AW-1:0] m_stride = '0;
  logic [AW-1:0] wq_a[$];
  logic [DW-1:0] wq_d[$];

  task automatic model_reset();
    m_busy = 0; m_ready = 0; m_done = 0; m_en = 0;
    m_addr = '0; m_wdata = '0; m_pix = 0; m_npix = 0;
    wq_a.delete(); wq_d.delete();
  endtask

  task automatic model_step();
    logic last_now, idle, done_n;
    int a;
    last_now = m_en && (wq_a.size() == 0);
    idle     = !m_busy && !m_done;
    done_n   = 1'b0;
    if (idle && start && size_out != 0) begin
      m_busy = 1; m_ready = 1; m_stride = ch_stride;
      m_pix = 0; m_npix = int'(size_out) * int'(size_out);
    end else if (m_ready && pe_valid) begin
      for (int k = 0; k < NC; k++) begin
        a = k * int'(m_stride) + m_pix;
        wq_a.push_back(a[AW-1:0]);
        wq_d.push_back(pe_data[k*DW +: DW]);
      end
      m_pix++;
      m_ready = 0;
    end
    if (wq_a.size() > 0) begin
      m_addr = wq_a.pop_front();
      m_wdata = wq_d.pop_front();
      m_en = 1;
    end else begin
      m_en = 0;
    end
    if (last_now) begin
      if (m_pix == m_npix) begin
        done_n = 1; m_busy = 0;
      end else begin
        m_ready = 1;
      end
    end
    m_done = done_n;
  endtask

  always @(negedge clk) begin
    if (reset) model_reset();
    chk("pe_ready", pe_ready, m_ready);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("enable", en, m_en);
    chk("write_en", we, m_en);
    chk("address", address_out, m_addr);
    chk("wdata_relu", wdata_out, relu(m_wdata));
    chk("enable_norelu", en0, m_en);
    chk("wdata_norelu", wdata_out0, m_wdata);
    if (!reset) model_step();
  end

  // Write log used by the literal checks.
  logic [AW-1:0] log_a[$];
  logic [DW-1:0] log_d[$];
  logic [DW-1:0] log_d0[$];
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (!reset && en) begin
      log_a.push_back(address_out);
      log_d.push_back(wdata_out);
    end
    if (!reset && en0) log_d0.push_back(wdata_out0);
    if (!reset && done) done_cnt++;
  end

  task automatic clear_logs();
    log_a.delete(); log_d.delete(); log_d0.delete(); done_cnt = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] s, input logic [AW-1:0] st);
    start = 1; size_out = s; ch_stride = st;
    cyc(1);
    start = 0;
  endtask

  task automatic run_to_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cyc(1);
      n++;
    end
    chk({name, "_done_seen"}, done_cnt > 0, 1);
    cyc(2);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < NC; k++) pe_data[k*DW +: DW] = DW'(k + 1);
  endtask

  logic [AW-1:0] exp_e[6] = '{16'h0000, 16'hFFF0, 16'hFFE0, 16'hFFD0, 16'hFFC0, 16'hFFB0};

  initial begin
    reset = 1; start = 0; size_out = 0; ch_stride = 0; pe_valid = 0; pe_data = '0;
    cyc(3);
    chk("rst_addr", address_out, 0);
    chk("rst_wdata", wdata_out, 0);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    cyc(1);

    // 2x2 map, stride 4, ramp data, producer always valid
    clear_logs();
    set_ramp();
    pe_valid = 1;
    do_start(8'd2, 16'd4);
    run_to_done("A", 200);
    chk("A_nwr", log_a.size(), 24);
    for (int k = 0; k < NC; k++) begin
      chk("A_p0_addr", log_a[k], 4 * k);
      chk("A_p0_data", log_d[k], k + 1);
      chk("A_p3_addr", log_a[18 + k], 3 + 4 * k);
    end
    chk("A_done_cnt", done_cnt, 1);
    chk("A_busy_after", busy, 0);

    // Stall in CAPTURE, ignored restart while busy, ReLU on/off data
    clear_logs();
    pe_valid = 0;
    pe_data = {16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000, 16'h0010, 16'hFFF0};
    do_start(8'd2, 16'd8);
    cyc(5);
    chk("B_stall_nwr", log_a.size(), 0);
    chk("B_stall_ready", pe_ready, 1);
    start = 1; size_out = 8'd1; ch_stride = 16'd0;
    cyc(1);
    start = 0;
    pe_valid = 1;
    run_to_done("B", 200);
    chk("B_nwr", log_a.size(), 24);
    chk("B_relu_ch0", log_d[0], 16'h0000);
    chk("B_relu_ch1", log_d[1], 16'h0010);
    chk("B_relu_ch2", log_d[2], 16'h0000);
    chk("B_relu_ch3", log_d[3], 16'h7FFF);
    chk("B_norelu_ch0", log_d0[0], 16'hFFF0);
    chk("B_ch1_addr", log_a[1], 16'd8);
    chk("B_p1_addr", log_a[6], 16'd1);

    // start with size_out=0 is ignored
    clear_logs();
    start = 1; size_out = 8'd0; ch_stride = 16'd4;
    cyc(1);
    start = 0;
    cyc(5);
    chk("C_busy", busy, 0);
    chk("C_nwr", log_a.size(), 0);

    // Reset during channel 3 of the first pixel, then a clean rerun
    clear_logs();
    set_ramp();
    pe_valid = 1;
    do_start(8'd2, 16'd4);
    cyc(4);
    chk("D_mid_en", en, 1);
    chk("D_mid_addr", address_out, 16'd12);
    chk("D_mid_data", wdata_out, 16'd4);
    reset = 1;
    #1;
    chk("D_rst_addr", address_out, 0);
    chk("D_rst_wdata", wdata_out, 0);
    chk("D_rst_en", en, 0);
    chk("D_rst_we", we, 0);
    chk("D_rst_ready", pe_ready, 0);
    chk("D_rst_busy", busy, 0);
    chk("D_rst_done", done, 0);
    cyc(1);
    reset = 0;
    cyc(1);
    clear_logs();
    do_start(8'd2, 16'd4);
    run_to_done("D", 200);
    chk("D_nwr", log_a.size(), 24);
    chk("D_first_addr", log_a[0], 16'd0);
    chk("D_first_data", log_d[0], 16'd1);
    chk("D_done_cnt", done_cnt, 1);

    // Address wrap with a 1x1 map
    clear_logs();
    do_start(8'd1, 16'hFFF0);
    run_to_done("E", 100);
    chk("E_nwr", log_a.size(), 6);
    for (int k = 0; k < 6; k++) chk("E_addr", log_a[k], exp_e[k]);
    chk("E_done_cnt", done_cnt, 1);

    pe_valid = 0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
